// File: rtl/ras_push_pop_ctrl.sv
// Return-address-stack sequencer: turns BPU call/return hints into RAS push/pop strobes,
// returns the predicted return target and forwards FTQ redirects as RAS snapshot strobes.
module ras_push_pop_ctrl #(
    parameter int ADDRW   = 32,
    parameter int INSTB   = 4,
    parameter int FTQIDXW = 6,
    parameter int CNTW    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_bpu_valid,
    output logic               o_bpu_ready,
    input  logic               i_bpu_is_call,
    input  logic               i_bpu_is_ret,
    input  logic [ADDRW-1:0]   i_bpu_call_pc,
    input  logic [FTQIDXW-1:0] i_bpu_ftq_idx,
    input  logic               i_ftq_redirct,
    output logic               o_ras_rable,
    output logic               o_ras_wable,
    output logic [ADDRW-1:0]   o_ras_din,
    output logic               o_ras_redirct,
    input  logic [ADDRW-1:0]   i_ras_dout,
    input  logic               i_ras_full,
    input  logic               i_ras_empty,
    output logic               o_pred_valid,
    output logic               o_pred_miss,
    output logic [ADDRW-1:0]   o_pred_target,
    output logic [FTQIDXW-1:0] o_pred_ftq_idx,
    output logic [CNTW-1:0]    o_ovf_cnt,
    output logic [CNTW-1:0]    o_udf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RET     = 2'd1,
        S_RETWAIT = 2'd2,
        S_CALL    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_is_call;
    logic [ADDRW-1:0]     r_call_pc;
    logic [FTQIDXW-1:0]   r_ftq_idx;
    logic                 r_pred_valid;
    logic                 r_pred_miss;
    logic [ADDRW-1:0]     r_pred_target;
    logic [FTQIDXW-1:0]   r_pred_ftq_idx;
    logic                 r_ras_redirct;
    logic [CNTW-1:0]      r_ovf_cnt;
    logic [CNTW-1:0]      r_udf_cnt;

    logic                 w_accept;
    logic                 w_rable;
    logic                 w_wable;
    logic                 w_pred_fire;
    logic                 w_pred_miss;
    logic                 w_udf_inc;
    logic                 w_ovf_inc;

    assign o_bpu_ready = (r_state == S_IDLE) & ~i_ftq_redirct;
    assign w_accept    = i_bpu_valid & o_bpu_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobe decode; a redirect forces IDLE and leaves every strobe low
    always_comb begin
        w_next      = r_state;
        w_rable     = 1'b0;
        w_wable     = 1'b0;
        w_pred_fire = 1'b0;
        w_pred_miss = 1'b0;
        w_udf_inc   = 1'b0;
        w_ovf_inc   = 1'b0;
        if (i_ftq_redirct) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_bpu_valid && i_bpu_is_ret) begin
                        w_next = S_RET;
                    end else if (i_bpu_valid && i_bpu_is_call) begin
                        w_next = S_CALL;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_RET: begin
                    if (!i_ras_empty) begin
                        w_rable = 1'b1;
                        w_next  = S_RETWAIT;
                    end else begin
                        w_udf_inc   = 1'b1;
                        w_pred_fire = 1'b1;
                        w_pred_miss = 1'b1;
                        w_next      = r_is_call ? S_CALL : S_IDLE;
                    end
                end
                S_RETWAIT: begin
                    w_pred_fire = 1'b1;
                    w_next      = r_is_call ? S_CALL : S_IDLE;
                end
                S_CALL: begin
                    if (!i_ras_full) begin
                        w_wable = 1'b1;
                    end else begin
                        w_ovf_inc = 1'b1;
                    end
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Request capture; a redirect drops whatever was latched
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_is_call <= 1'b0;
            r_call_pc <= '0;
            r_ftq_idx <= '0;
        end else if (i_ftq_redirct) begin
            r_is_call <= 1'b0;
            r_call_pc <= '0;
            r_ftq_idx <= '0;
        end else if (w_accept) begin
            r_is_call <= i_bpu_is_call;
            r_call_pc <= i_bpu_call_pc;
            r_ftq_idx <= i_bpu_ftq_idx;
        end
    end

    // Prediction result, snapshot strobe and saturating drop counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pred_valid   <= 1'b0;
            r_pred_miss    <= 1'b0;
            r_pred_target  <= '0;
            r_pred_ftq_idx <= '0;
            r_ras_redirct  <= 1'b0;
            r_ovf_cnt      <= '0;
            r_udf_cnt      <= '0;
        end else begin
            r_ras_redirct <= i_ftq_redirct;
            r_pred_valid  <= w_pred_fire;
            r_pred_miss   <= w_pred_fire & w_pred_miss;
            if (w_pred_fire) begin
                r_pred_target  <= w_pred_miss ? '0 : i_ras_dout;
                r_pred_ftq_idx <= r_ftq_idx;
            end
            if (w_ovf_inc && (r_ovf_cnt != {CNTW{1'b1}})) begin
                r_ovf_cnt <= r_ovf_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (w_udf_inc && (r_udf_cnt != {CNTW{1'b1}})) begin
                r_udf_cnt <= r_udf_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_ras_rable    = w_rable;
    assign o_ras_wable    = w_wable;
    assign o_ras_din      = w_wable ? (r_call_pc + ADDRW'(INSTB)) : '0;
    assign o_ras_redirct  = r_ras_redirct;
    assign o_pred_valid   = r_pred_valid;
    assign o_pred_miss    = r_pred_miss;
    assign o_pred_target  = r_pred_target;
    assign o_pred_ftq_idx = r_pred_ftq_idx;
    assign o_ovf_cnt      = r_ovf_cnt;
    assign o_udf_cnt      = r_udf_cnt;

endmodule
